button_mode_controller: RTL and testbench

- Sequencing controller for the alarm-clock user interface. It sits directly downstream of the five-channel debouncer and consumes its clean button levels.
- Detects press edges, generates auto-repeat on held UP/DOWN, and runs the setting-mode FSM.
- Issues one-cycle command pulses to the timekeeping and alarm blocks. System clock is 100 Hz (10 ms period), so all tick counts are in 10 ms units.

---
 rtl/button_mode_controller.sv | 119 +++++++++++
 tb/tb_button_mode_controller.sv | 128 ++++++++++++
 2 files changed

// File: rtl/button_mode_controller.sv
// button_mode_controller: press edges, UP/DOWN auto-repeat and setting-mode FSM for the alarm-clock UI.
module button_mode_controller #(
    parameter int LONG_PRESS_TICKS = 100,
    parameter int REPEAT_TICKS     = 20,
    parameter int TIMEOUT_TICKS    = 3000,
    parameter int CNT_W            = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_alarm,
    input  logic       btn_snooze,
    input  logic       alarm_ringing,
    output logic [2:0] mode,
    output logic       set_active,
    output logic       inc_pulse,
    output logic       dec_pulse,
    output logic       alarm_en,
    output logic       snooze_pulse,
    output logic       alarm_stop_pulse
);
    typedef enum logic [2:0] {
        NORMAL    = 3'd0,
        SET_T_HR  = 3'd1,
        SET_T_MIN = 3'd2,
        SET_A_HR  = 3'd3,
        SET_A_MIN = 3'd4
    } state_t;
    localparam logic [CNT_W-1:0] LONG_C  = CNT_W'(LONG_PRESS_TICKS);
    localparam logic [CNT_W-1:0] REP_C   = CNT_W'(REPEAT_TICKS);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_TICKS - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    state_t           mode_q, mode_d;
    logic [4:0]       btn, prev_q, rise;
    logic [CNT_W-1:0] hold_q, hold_d, idle_q, idle_d;
    logic             rep_q, rep_d;
    logic             set_active_q, set_active_d;
    logic             inc_q, inc_d, dec_q, dec_d;
    logic             alarm_en_q, alarm_en_d, snooze_q, snooze_d, stop_q, stop_d;
    logic             in_set, both, auto_p, activity, timeout;
    assign btn  = {btn_snooze, btn_alarm, btn_down, btn_up, btn_mode};
    assign rise = btn & ~prev_q;
    always_comb begin
        in_set   = mode_q inside {SET_T_HR, SET_T_MIN, SET_A_HR, SET_A_MIN};
        both     = btn_up & btn_down;
        // hold_q == 0 means no repeat is armed; it counts from 1 after each pulse
        auto_p   = in_set & ~rise[0] & ~|rise[2:1] & (btn_up ^ btn_down) & (hold_q != '0)
                 & (hold_q == (rep_q ? REP_C : LONG_C));
        activity = |rise | auto_p;
        timeout  = in_set & ~activity & (idle_q == TO_LAST);
        mode_d   = mode_q;
        hold_d   = '0;
        rep_d    = 1'b0;
        idle_d   = '0;
        inc_d    = 1'b0;
        dec_d    = 1'b0;
        if (rise[0])
            mode_d = (mode_q == NORMAL) ? SET_T_HR
                   : (mode_q inside {SET_T_HR, SET_T_MIN, SET_A_HR}) ? state_t'(mode_q + 3'd1)
                   : NORMAL;
        else if (!in_set || timeout)
            mode_d = NORMAL;
        else begin
            idle_d = activity ? '0 : idle_q + ONE;
            if (!both && (rise[1] || rise[2])) begin
                inc_d  = rise[1];
                dec_d  = rise[2];
                hold_d = ONE;
            end else if (auto_p) begin
                inc_d  = btn_up;
                dec_d  = btn_down;
                hold_d = ONE;
                rep_d  = 1'b1;
            end else if (!both && (btn_up || btn_down) && hold_q != '0) begin
                hold_d = hold_q + ONE;
                rep_d  = rep_q;
            end
        end
        set_active_d = mode_d != NORMAL;
        alarm_en_d   = alarm_en_q ^ (rise[3] & ~alarm_ringing);
        stop_d       = rise[3] & alarm_ringing;
        snooze_d     = rise[4] & alarm_ringing;
    end
    always_ff @(posedge clk) begin
        prev_q <= btn;
        if (rst) begin
            mode_q       <= NORMAL;
            hold_q       <= '0;
            idle_q       <= '0;
            rep_q        <= 1'b0;
            set_active_q <= 1'b0;
            inc_q        <= 1'b0;
            dec_q        <= 1'b0;
            alarm_en_q   <= 1'b0;
            snooze_q     <= 1'b0;
            stop_q       <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            hold_q       <= hold_d;
            idle_q       <= idle_d;
            rep_q        <= rep_d;
            set_active_q <= set_active_d;
            inc_q        <= inc_d;
            dec_q        <= dec_d;
            alarm_en_q   <= alarm_en_d;
            snooze_q     <= snooze_d;
            stop_q       <= stop_d;
        end
    end
    assign mode             = mode_q;
    assign set_active       = set_active_q;
    assign inc_pulse        = inc_q;
    assign dec_pulse        = dec_q;
    assign alarm_en         = alarm_en_q;
    assign snooze_pulse     = snooze_q;
    assign alarm_stop_pulse = stop_q;
endmodule

// File: tb/tb_button_mode_controller.sv
// tb_button_mode_controller: scoreboard bench with short tick parameters.
module tb_button_mode_controller;
    localparam logic [4:0] M = 5'd1, U = 5'd2, D = 5'd4, A = 5'd8, S = 5'd16, N = 5'd0;
    localparam logic [3:0] P_INC = 4'b1000, P_DEC = 4'b0100, P_SNZ = 4'b0010, P_STP = 4'b0001, P0 = 4'b0000;
    typedef struct {
        string      tag;
        logic [8:0] v;
    } exp_t;
    logic       clk = 1'b0, rst = 1'b1;
    logic       btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_alarm = 1'b0, btn_snooze = 1'b0;
    logic       alarm_ringing = 1'b0;
    logic [2:0] mode;
    logic       set_active, inc_pulse, dec_pulse, alarm_en, snooze_pulse, alarm_stop_pulse;
    logic       exp_en = 1'b0;
    int         total = 0, bad = 0;
    exp_t       sb[$];
    button_mode_controller #(
        .LONG_PRESS_TICKS(5),
        .REPEAT_TICKS(2),
        .TIMEOUT_TICKS(20),
        .CNT_W(12)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_mode(btn_mode),
        .btn_up(btn_up),
        .btn_down(btn_down),
        .btn_alarm(btn_alarm),
        .btn_snooze(btn_snooze),
        .alarm_ringing(alarm_ringing),
        .mode(mode),
        .set_active(set_active),
        .inc_pulse(inc_pulse),
        .dec_pulse(dec_pulse),
        .alarm_en(alarm_en),
        .snooze_pulse(snooze_pulse),
        .alarm_stop_pulse(alarm_stop_pulse)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got mode/set/inc/dec/en/snz/stp=%b expected %b", tag, got, exp);
        end
    endtask
    // Drive one cycle of inputs; outputs after the following edge must match.
    task automatic cyc(input string tag, input logic [4:0] b, input logic ring,
                       input logic [2:0] emode, input logic [3:0] p);
        exp_t e;
        @(negedge clk);
        {btn_snooze, btn_alarm, btn_down, btn_up, btn_mode} = b;
        alarm_ringing = ring;
        sb.push_back('{tag, {emode, emode != 3'd0, p[3], p[2], exp_en, p[1], p[0]}});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check(e.tag, {mode, set_active, inc_pulse, dec_pulse, alarm_en, snooze_pulse, alarm_stop_pulse}, e.v);
    endtask
    initial begin
        rst = 1'b1;
        cyc("reset", U, 1'b0, 3'd0, P0);
        cyc("reset", U, 1'b0, 3'd0, P0);
        rst = 1'b0;
        cyc("rst_release_up_held", U, 1'b0, 3'd0, P0);
        cyc("up_release", N, 1'b0, 3'd0, P0);
        for (int i = 1; i <= 5; i++) begin
            cyc("mode_step", M, 1'b0, 3'(i % 5), P0);
            cyc("mode_hold", N, 1'b0, 3'(i % 5), P0);
        end
        cyc("normal_up", U, 1'b0, 3'd0, P0);
        cyc("normal_up_rel", N, 1'b0, 3'd0, P0);
        cyc("normal_dn", D, 1'b0, 3'd0, P0);
        cyc("normal_dn_rel", N, 1'b0, 3'd0, P0);
        cyc("to_set_t_hr", M, 1'b0, 3'd1, P0);
        cyc("mode_rel", N, 1'b0, 3'd1, P0);
        for (int k = 0; k < 12; k++)
            cyc("up_repeat", U, 1'b0, 3'd1, (k == 0 || k == 5 || k == 7 || k == 9 || k == 11) ? P_INC : P0);
        for (int k = 0; k < 4; k++)
            cyc("up_released", N, 1'b0, 3'd1, P0);
        cyc("to_set_t_min", M, 1'b0, 3'd2, P0);
        cyc("mode_rel", N, 1'b0, 3'd2, P0);
        cyc("up_rise", U, 1'b0, 3'd2, P_INC);
        cyc("up_held", U, 1'b0, 3'd2, P0);
        for (int k = 0; k < 6; k++)
            cyc("up_dn_both", U | D, 1'b0, 3'd2, P0);
        for (int k = 0; k < 6; k++)
            cyc("dn_left_held", D, 1'b0, 3'd2, P0);
        cyc("dn_release", N, 1'b0, 3'd2, P0);
        cyc("dn_repress", D, 1'b0, 3'd2, P_DEC);
        cyc("dn_rel", N, 1'b0, 3'd2, P0);
        for (int i = 3; i <= 6; i++) begin
            cyc("cycle_to_hr", M, 1'b0, 3'(i % 5), P0);
            cyc("mode_rel", N, 1'b0, 3'(i % 5), P0);
        end
        cyc("mode_and_up", M | U, 1'b0, 3'd2, P0);
        for (int k = 0; k < 6; k++)
            cyc("mode_up_held", M | U, 1'b0, 3'd2, P0);
        cyc("release_all", N, 1'b0, 3'd2, P0);
        cyc("to_set_a_hr", M, 1'b0, 3'd3, P0);
        for (int k = 0; k < 19; k++)
            cyc("idle_in_set", N, 1'b0, 3'd3, P0);
        cyc("timeout", N, 1'b0, 3'd0, P0);
        exp_en = 1'b1;
        cyc("alarm_on", A, 1'b0, 3'd0, P0);
        cyc("alarm_rel", N, 1'b0, 3'd0, P0);
        cyc("ring_stop", A, 1'b1, 3'd0, P_STP);
        cyc("ring_rel", N, 1'b1, 3'd0, P0);
        cyc("ring_snooze", S, 1'b1, 3'd0, P_SNZ);
        cyc("snooze_rel", N, 1'b1, 3'd0, P0);
        cyc("snooze_quiet", S, 1'b0, 3'd0, P0);
        cyc("snooze_quiet_rel", N, 1'b0, 3'd0, P0);
        exp_en = 1'b0;
        cyc("alarm_off", A, 1'b0, 3'd0, P0);
        cyc("alarm_rel", N, 1'b0, 3'd0, P0);
        cyc("to_set_t_hr2", M, 1'b0, 3'd1, P0);
        cyc("mode_rel", N, 1'b0, 3'd1, P0);
        cyc("up_rise2", U, 1'b0, 3'd1, P_INC);
        cyc("up_held2", U, 1'b0, 3'd1, P0);
        rst = 1'b1;
        cyc("mid_reset", U, 1'b0, 3'd0, P0);
        rst = 1'b0;
        for (int k = 0; k < 7; k++)
            cyc("after_reset_held", U, 1'b0, 3'd0, P0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
